// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS-subset datapath: an FSM steps each instruction through fetch, decode,
// execute, memory and writeback, talking to instruction/data memories over req/ready handshakes.
module multicycle_datapath #(
   parameter logic [31:0] RESET_PC        = 32'h0000_1000,
   parameter int          NREGS           = 32,
   parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic        retire,
   output logic        halted,
   output logic [31:0] dbg_pc
);

   localparam int RW = $clog2(NREGS);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      HALT
   } state_t;

   state_t state_q, state_d;

   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] aluOut_q, aluOut_d;
   logic [31:0] mdr_q, mdr_d;

   logic [31:0] regFile [NREGS];

   logic [5:0]    opcode;
   logic [5:0]    funct;
   logic [RW-1:0] rsIdx;
   logic [RW-1:0] rtIdx;
   logic [RW-1:0] rdIdx;
   logic [RW-1:0] wrIdx;
   logic [31:0]   immSext;
   logic [31:0]   immZext;
   logic [31:0]   branchOff;
   logic [31:0]   jumpTarget;
   logic [31:0]   rsVal;
   logic [31:0]   rtVal;
   logic [31:0]   wrData;
   logic [31:0]   aluResult;
   logic          isRtype, isAddi, isOri, isLw, isSw, isBeq, isJ, isLegal;
   logic          wrEn;

   // Register specifiers are truncated to the width the register file actually has.
   assign opcode     = ir_q[31:26];
   assign funct      = ir_q[5:0];
   assign rsIdx      = ir_q[21 +: RW];
   assign rtIdx      = ir_q[16 +: RW];
   assign rdIdx      = ir_q[11 +: RW];
   assign immSext    = {{16{ir_q[15]}}, ir_q[15:0]};
   assign immZext    = {16'h0000, ir_q[15:0]};
   assign branchOff  = {immSext[29:0], 2'b00};
   assign jumpTarget = {pc_q[31:28], ir_q[25:0], 2'b00};

   assign isRtype = (opcode == OP_RTYPE) &&
                    ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                     (funct == FN_OR)  || (funct == FN_SLT));
   assign isAddi  = (opcode == OP_ADDI);
   assign isOri   = (opcode == OP_ORI);
   assign isLw    = (opcode == OP_LW);
   assign isSw    = (opcode == OP_SW);
   assign isBeq   = (opcode == OP_BEQ);
   assign isJ     = (opcode == OP_J);
   assign isLegal = isRtype | isAddi | isOri | isLw | isSw | isBeq | isJ;

   assign rsVal = (rsIdx == '0) ? 32'h0 : regFile[rsIdx];
   assign rtVal = (rtIdx == '0) ? 32'h0 : regFile[rtIdx];

   // Loads and stores share the addi adder for their effective address.
   always_comb begin
      aluResult = 32'h0;
      if (isRtype) begin
         case (funct)
            FN_ADD:  aluResult = a_q + b_q;
            FN_SUB:  aluResult = a_q - b_q;
            FN_AND:  aluResult = a_q & b_q;
            FN_OR:   aluResult = a_q | b_q;
            FN_SLT:  aluResult = {31'h0, ($signed(a_q) < $signed(b_q))};
            default: aluResult = 32'h0;
         endcase
      end else if (isOri) begin
         aluResult = a_q | immZext;
      end else begin
         aluResult = a_q + immSext;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH: begin
            if (imem_ready) begin
               state_d = DECODE;
            end
         end
         DECODE: begin
            if (isLegal) begin
               state_d = EXEC;
            end else if (HALT_ON_ILLEGAL) begin
               state_d = HALT;
            end else begin
               state_d = FETCH;
            end
         end
         EXEC: begin
            if (isLw || isSw) begin
               state_d = MEM;
            end else if (isBeq || isJ) begin
               state_d = FETCH;
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            if (dmem_ready) begin
               if (isLw) begin
                  state_d = WB;
               end else begin
                  state_d = FETCH;
               end
            end
         end
         WB:      state_d = FETCH;
         HALT:    state_d = HALT;
         default: state_d = FETCH;
      endcase
   end

   // PC already points past the branch when EXEC runs, so the offset is added to PC+4.
   always_comb begin
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      aluOut_d = aluOut_q;
      mdr_d    = mdr_q;
      case (state_q)
         FETCH: begin
            if (imem_ready) begin
               ir_d = imem_rdata;
               pc_d = pc_q + 32'd4;
            end
         end
         DECODE: begin
            a_d = rsVal;
            b_d = rtVal;
         end
         EXEC: begin
            aluOut_d = aluResult;
            if (isBeq && (a_q == b_q)) begin
               pc_d = pc_q + branchOff;
            end else if (isJ) begin
               pc_d = jumpTarget;
            end
         end
         MEM: begin
            if (dmem_ready && isLw) begin
               mdr_d = dmem_rdata;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         ir_q     <= 32'h0;
         a_q      <= 32'h0;
         b_q      <= 32'h0;
         aluOut_q <= 32'h0;
         mdr_q    <= 32'h0;
      end else begin
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         aluOut_q <= aluOut_d;
         mdr_q    <= mdr_d;
      end
   end

   // The register file is deliberately left uninitialised across reset.
   assign wrEn   = (state_q == WB) && !reset;
   assign wrIdx  = isRtype ? rdIdx : rtIdx;
   assign wrData = isLw ? mdr_q : aluOut_q;

   always_ff @(posedge clk) begin
      if (wrEn && (wrIdx != '0)) begin
         regFile[wrIdx] <= wrData;
      end
   end

   always_comb begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      retire   = 1'b0;
      halted   = 1'b0;
      if (!reset) begin
         case (state_q)
            FETCH:  imem_req = 1'b1;
            DECODE: retire   = !isLegal && !HALT_ON_ILLEGAL;
            EXEC:   retire   = isBeq || isJ;
            MEM: begin
               dmem_req = 1'b1;
               retire   = isSw && dmem_ready;
            end
            WB:     retire   = 1'b1;
            HALT:   halted   = 1'b1;
            default: begin
            end
         endcase
      end
   end

   assign imem_addr  = pc_q;
   assign dmem_addr  = aluOut_q;
   assign dmem_we    = isSw;
   assign dmem_wdata = b_q;
   assign dbg_pc     = pc_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench for multicycle_datapath: a random instruction stream is checked against an
// instruction-level reference model, plus directed reset, branch, halt and illegal-as-NOP scenarios.
`timescale 1ns/1ps
module tb_multicycle_datapath;

   localparam logic [31:0] RESET_PC = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic [31:0] imemRdata;
   logic        imemReady;
   logic        dmemReq;
   logic        dmemWe;
   logic [31:0] dmemAddr;
   logic [31:0] dmemWdata;
   logic [31:0] dmemRdata;
   logic        dmemReady;
   logic        retire;
   logic        halted;
   logic [31:0] dbgPc;

   logic        nopImemReq;
   logic [31:0] nopImemAddr;
   logic        nopDmemReq;
   logic        nopDmemWe;
   logic [31:0] nopDmemAddr;
   logic [31:0] nopDmemWdata;
   logic        nopRetire;
   logic        nopHalted;
   logic [31:0] nopPc;

   logic [31:0] mReg [32];
   logic [31:0] mPc;
   logic [31:0] tbMem [logic [31:0]];

   int          testsRun = 0;
   int          testsFailed = 0;
   int          lastCycles;
   int          lastMemCycles;
   logic [31:0] lastStoreData;

   logic [5:0]  functs [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

   always #5 clk = ~clk;

   multicycle_datapath #(
      .RESET_PC(RESET_PC),
      .NREGS(32),
      .HALT_ON_ILLEGAL(1'b1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .imem_req(imemReq),
      .imem_addr(imemAddr),
      .imem_rdata(imemRdata),
      .imem_ready(imemReady),
      .dmem_req(dmemReq),
      .dmem_we(dmemWe),
      .dmem_addr(dmemAddr),
      .dmem_wdata(dmemWdata),
      .dmem_rdata(dmemRdata),
      .dmem_ready(dmemReady),
      .retire(retire),
      .halted(halted),
      .dbg_pc(dbgPc)
   );

   // A second core that always fetches opcode 0x3F and treats it as a NOP.
   multicycle_datapath #(
      .RESET_PC(RESET_PC),
      .NREGS(32),
      .HALT_ON_ILLEGAL(1'b0)
   ) nopDut (
      .clk(clk),
      .reset(reset),
      .imem_req(nopImemReq),
      .imem_addr(nopImemAddr),
      .imem_rdata(32'hFC00_0000),
      .imem_ready(1'b1),
      .dmem_req(nopDmemReq),
      .dmem_we(nopDmemWe),
      .dmem_addr(nopDmemAddr),
      .dmem_wdata(nopDmemWdata),
      .dmem_rdata(32'h0),
      .dmem_ready(1'b0),
      .retire(nopRetire),
      .halted(nopHalted),
      .dbg_pc(nopPc)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   function automatic logic [31:0] rType(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd);
      return {6'h00, rs, rt, rd, 5'h00, fn};
   endfunction

   function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] jType(input logic [25:0] target);
      return {6'h02, target};
   endfunction

   task automatic applyReset();
      reset     = 1'b1;
      imemReady = 1'b0;
      dmemReady = 1'b0;
      repeat (2) begin
         #1;
         checkOutput("rstImemReq", imemReq, 0);
         checkOutput("rstDmemReq", dmemReq, 0);
         checkOutput("rstRetire", retire, 0);
         checkOutput("rstHalted", halted, 0);
         @(negedge clk);
      end
      checkOutput("rstPc", dbgPc, RESET_PC);
      reset = 1'b0;
      mPc   = RESET_PC;
   endtask

   // Executes one instruction in the model, then drives the DUT through it cycle by cycle.
   // Entered and left at a falling edge; the first cycle is the fetch cycle.
   task automatic applyStimulus(input logic [31:0] instr, input int iw, input int dw);
      logic [5:0]  op, fn;
      logic [4:0]  rs, rt, rd, dest;
      logic [31:0] a, b, sImm, zImm, res, nextPc, memAddr, loadData;
      bit          isLoad, isStore, writesReg, fetched, memDone, done;
      int          expLat, cyc, iLeft, dLeft, memCycles;

      op = instr[31:26]; fn = instr[5:0];
      rs = instr[25:21]; rt = instr[20:16]; rd = instr[15:11];
      a = mReg[rs]; b = mReg[rt];
      sImm = {{16{instr[15]}}, instr[15:0]};
      zImm = {16'h0000, instr[15:0]};
      nextPc = mPc + 32'd4;
      isLoad = 0; isStore = 0; writesReg = 0;
      res = 0; memAddr = 0; loadData = 0; dest = 0; expLat = 4;
      case (op)
         6'h00: begin
            dest = rd; writesReg = 1;
            case (fn)
               6'h20:   res = a + b;
               6'h22:   res = a - b;
               6'h24:   res = a & b;
               6'h25:   res = a | b;
               6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               default: writesReg = 0;
            endcase
         end
         6'h08: begin dest = rt; writesReg = 1; res = a + sImm; end
         6'h0D: begin dest = rt; writesReg = 1; res = a | zImm; end
         6'h23: begin
            isLoad = 1; dest = rt; writesReg = 1; expLat = 5;
            memAddr = a + sImm;
            if (!tbMem.exists(memAddr)) tbMem[memAddr] = $urandom;
            loadData = tbMem[memAddr];
            res = loadData;
         end
         6'h2B: begin isStore = 1; memAddr = a + sImm; end
         6'h04: begin
            expLat = 3;
            if (a == b) nextPc = mPc + 32'd4 + (sImm << 2);
         end
         6'h02: begin
            expLat = 3;
            nextPc = {nextPc[31:28], instr[25:0], 2'b00};
         end
         default: begin end
      endcase
      expLat = expLat + iw + ((isLoad || isStore) ? dw : 0);

      cyc = 0; iLeft = iw; dLeft = dw; memCycles = 0;
      fetched = 0; memDone = 0; done = 0;
      while (!done && cyc < 40) begin
         cyc++;
         #1;
         imemReady = 1'b0; dmemReady = 1'b0;
         imemRdata = $urandom; dmemRdata = $urandom;
         if (cyc == 1) checkOutput("dbgPc", dbgPc, mPc);
         if ((isLoad || isStore) && fetched && !memDone && dmemReq) begin
            memCycles++;
            checkOutput("dmemAddr", dmemAddr, memAddr);
            checkOutput("dmemWe", dmemWe, isStore);
            if (isStore) checkOutput("dmemWdata", dmemWdata, b);
            if (dLeft == 0) begin
               dmemReady = 1'b1; dmemRdata = loadData; memDone = 1;
               if (isStore) lastStoreData = dmemWdata;
            end else begin
               dLeft--;
            end
         end else begin
            checkOutput("dmemIdle", dmemReq, 0);
         end
         if (!fetched) begin
            checkOutput("imemReq", imemReq, 1);
            checkOutput("imemAddr", imemAddr, mPc);
            if (imemReq) begin
               if (iLeft == 0) begin
                  imemReady = 1'b1; imemRdata = instr; fetched = 1;
               end else begin
                  iLeft--;
               end
            end
         end else begin
            checkOutput("imemIdle", imemReq, 0);
         end
         #1;
         if (retire) done = 1;
         @(negedge clk);
      end
      imemReady = 1'b0; dmemReady = 1'b0;
      checkOutput("retireSeen", done, 1);
      checkOutput("cycles", cyc, expLat);
      if (isLoad || isStore) checkOutput("memDone", memDone, 1);
      lastCycles = cyc;
      lastMemCycles = memCycles;
      if (writesReg && dest != 0) mReg[dest] = res;
      if (isStore) tbMem[memAddr] = b;
      mPc = nextPc;
   endtask

   task automatic applyIllegalHalt();
      #1;
      checkOutput("illImemReq", imemReq, 1);
      checkOutput("illImemAddr", imemAddr, mPc);
      imemReady = 1'b1; imemRdata = 32'hFC00_0000;
      @(negedge clk);
      #1;
      imemReady = 1'b0;
      checkOutput("illDecodeHalted", halted, 0);
      checkOutput("illDecodeRetire", retire, 0);
      @(negedge clk);
      repeat (5) begin
         #1;
         checkOutput("haltHalted", halted, 1);
         checkOutput("haltImemReq", imemReq, 0);
         checkOutput("haltDmemReq", dmemReq, 0);
         checkOutput("haltRetire", retire, 0);
         checkOutput("haltPc", dbgPc, mPc + 32'd4);
         @(negedge clk);
      end
   endtask

   task automatic checkNopCore();
      bit          found;
      logic [31:0] pc0;
      found = 0;
      for (int k = 0; k < 4 && !found; k++) begin
         #1;
         if (nopRetire) found = 1;
         else @(negedge clk);
      end
      checkOutput("nopRetireSeen", found, 1);
      pc0 = nopPc;
      for (int rep = 1; rep <= 3; rep++) begin
         @(negedge clk); #1;
         checkOutput("nopGapRetire", nopRetire, 0);
         checkOutput("nopFetchReq", nopImemReq, 1);
         checkOutput("nopFetchAddr", nopImemAddr, pc0 + 32'(4 * (rep - 1)));
         @(negedge clk); #1;
         checkOutput("nopRetire", nopRetire, 1);
         checkOutput("nopPc", nopPc, pc0 + 32'(4 * rep));
         checkOutput("nopHalted", nopHalted, 0);
         checkOutput("nopDmemReq", nopDmemReq, 0);
      end
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      imemRdata = 32'h0; dmemRdata = 32'h0;
      lastStoreData = 32'h0; lastCycles = 0; lastMemCycles = 0;
      for (int r = 0; r < 32; r++) mReg[r] = 32'h0;

      applyReset();

      applyStimulus(iType(6'h08, 5'd0, 5'd1, 16'd5), 0, 0);
      checkOutput("retireCycle4", lastCycles, 4);
      applyStimulus(iType(6'h08, 5'd0, 5'd2, 16'd7), 0, 0);
      checkOutput("retireCycle8", lastCycles, 4);
      applyStimulus(rType(6'h20, 5'd1, 5'd2, 5'd3), 0, 0);
      checkOutput("retireCycle12", lastCycles, 4);

      applyStimulus(iType(6'h2B, 5'd0, 5'd3, 16'h0010), 0, 2);
      checkOutput("swData12", lastStoreData, 32'd12);
      checkOutput("swHeld3", lastMemCycles, 3);
      applyStimulus(iType(6'h23, 5'd0, 5'd4, 16'h0010), 0, 2);
      checkOutput("lwCycles7", lastCycles, 7);
      applyStimulus(iType(6'h2B, 5'd0, 5'd4, 16'h0014), 0, 0);
      checkOutput("lwData12", lastStoreData, 32'd12);

      applyStimulus(iType(6'h04, 5'd1, 5'd2, 16'd4), 0, 0);
      checkOutput("beqNotTakenPc", dbgPc, 32'h0000_101C);
      applyStimulus(iType(6'h08, 5'd0, 5'd0, 16'd9), 0, 0);
      applyStimulus(iType(6'h2B, 5'd0, 5'd0, 16'h0018), 0, 0);
      checkOutput("reg0Zero", lastStoreData, 32'd0);
      applyStimulus(jType(26'h0000400), 1, 0);
      checkOutput("jumpPc", dbgPc, 32'h0000_1000);
      repeat (2) begin
         applyStimulus(iType(6'h04, 5'd1, 5'd1, 16'hFFFF), 0, 0);
         checkOutput("beqLoopCycles", lastCycles, 3);
         checkOutput("beqLoopPc", dbgPc, 32'h0000_1000);
      end

      for (int r = 1; r < 32; r++) begin
         applyStimulus(iType(6'h08, 5'd0, 5'(r), 16'($urandom)), 0, 0);
      end

      for (int n = 0; n < 300; n++) begin
         logic [31:0] instr;
         logic [4:0]  rs, rt, rd;
         int          kind, off;
         kind = $urandom_range(0, 9);
         rs = 5'($urandom_range(0, 31));
         rt = 5'($urandom_range(0, 31));
         rd = 5'($urandom_range(0, 31));
         case (kind)
            0, 1, 2: instr = rType(functs[$urandom_range(0, 4)], rs, rt, rd);
            3:       instr = iType(6'h08, rs, rt, 16'($urandom));
            4:       instr = iType(6'h0D, rs, rt, 16'($urandom));
            5:       instr = iType(6'h23, 5'd0, rt, 16'($urandom_range(0, 63) * 4));
            6, 7:    instr = iType(6'h2B, 5'd0, rt, 16'($urandom_range(0, 63) * 4));
            8: begin
               off = $urandom_range(0, 15) - 8;
               if ($urandom_range(0, 1) == 1) rt = rs;
               instr = iType(6'h04, rs, rt, off[15:0]);
            end
            default: instr = jType(26'($urandom));
         endcase
         applyStimulus(instr, $urandom_range(0, 2), $urandom_range(0, 2));
      end

      applyIllegalHalt();
      checkNopCore();

      applyReset();
      repeat (3) begin
         #1;
         checkOutput("waitImemReq", imemReq, 1);
         checkOutput("waitImemAddr", imemAddr, RESET_PC);
         imemReady = 1'b0;
         @(negedge clk);
      end
      reset = 1'b1;
      imemReady = 1'b1;
      imemRdata = iType(6'h08, 5'd0, 5'd5, 16'd3);
      #1;
      checkOutput("midRstImemReq", imemReq, 0);
      checkOutput("midRstDmemReq", dmemReq, 0);
      @(negedge clk);
      reset = 1'b0;
      imemReady = 1'b0;
      mPc = RESET_PC;

      applyStimulus(iType(6'h08, 5'd0, 5'd1, 16'hFFFF), 0, 0);
      applyStimulus(iType(6'h08, 5'd0, 5'd2, 16'd1), 0, 0);
      applyStimulus(rType(6'h2A, 5'd1, 5'd2, 5'd3), 0, 0);
      applyStimulus(iType(6'h2B, 5'd0, 5'd3, 16'h0000), 0, 0);
      checkOutput("sltNegLess", lastStoreData, 32'd1);
      applyStimulus(rType(6'h2A, 5'd2, 5'd1, 5'd6), 0, 0);
      applyStimulus(iType(6'h2B, 5'd0, 5'd6, 16'h0004), 1, 1);
      checkOutput("sltPosNotLess", lastStoreData, 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
